mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction/data cache pair.
- Arbitrates the icache fill/fetch port and the dcache read/write port onto the single RAM port.
- Returns per-requester wait/load signals.
- Registered-grant FSM with data priority, an instruction anti-starvation counter and an access-timeout watchdog.

Parameters:
STARVE_MAX, 4, consecutive data grants allowed while iREN is pending before instruction is forced next
TIMEOUT, 64, cycles in a grant state without ramstate==ACCESS before the timeout flag is raised

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
iREN  in  1  instruction read request from icache
iaddr  in  32  instruction address
iwait  out  1  low for exactly the cycle instruction data is valid
iload  out  32  instruction read data
dREN  in  1  data read request from dcache
dWEN  in  1  data write request from dcache
daddr  in  32  data address
dstore  in  32  data write value
dwait  out  1  low for exactly the cycle the data access completes
dload  out  32  data read data
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
timeout  out  1  sticky watchdog flag
starve_cnt  out  3  current consecutive-data-grant count (debug)

Behaviour:
- Reset: synchronous, checked on the CLK edge, and overrides everything including mid-access.
  - Values after the edge: state=IDLE, starve_cnt=0, watchdog=0, timeout=0, iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
- FSM states and transitions:
  - IDLE: no RAM drive. Next state from requests sampled this cycle:
    - dREN|dWEN and not (iREN and starve_cnt==STARVE_MAX) -> DGRANT.
    - else iREN -> IGRANT.
    - else stay.
  - DGRANT: ramaddr=daddr; ramWEN=dWEN; ramREN=dREN&~dWEN (write dominates if both asserted); ramstore=dstore.
    - On ramstate==ACCESS: dwait=0 and dload=ramload that cycle -> IDLE.
  - IGRANT: ramaddr=iaddr; ramREN=1; ramWEN=0.
    - On ACCESS: iwait=0 and iload=ramload that cycle -> IDLE.
- RAM-side outputs and wait/load are combinational from the registered state, the granted requester's inputs and ramstate.
  - Requesters hold address/data stable while their wait is high.
  - The non-granted requester always sees wait=1.
- Latency:
  - Request in IDLE at cycle 0 -> RAM driven from cycle 1.
  - Completion in the first cycle ramstate==ACCESS.
  - One mandatory IDLE turnaround cycle follows every grant; back-to-back accesses take a minimum of 2 cycles each.
- Abort: if the granted requester drops its enable while in a grant state, RAM enables go low the same cycle and the FSM goes to IDLE next edge. No wait-low pulse is issued.
- ERROR: ramstate==ERROR in a grant state keeps wait=1 and returns to IDLE next edge. Arbitration is redone and a data retry may win again.
- Starvation counter:
  - +1 on each DGRANT completion while iREN is high, saturating at STARVE_MAX.
  - Cleared on IGRANT completion.
  - Cleared on any DGRANT completion with iREN low.
- Watchdog:
  - Counts cycles in a grant state; cleared on entering IDLE.
  - Reaching TIMEOUT sets timeout=1, held until RST.
  - The FSM keeps waiting; no forced abort.
- Simultaneous iREN and dREN/dWEN in IDLE with starve_cnt<STARVE_MAX: data wins.

Decomposition:
- cpu_types_pkg: ramstate_t, word_t.
- New in cpu_types_pkg: arb_state_t {IDLE, IGRANT, DGRANT}.
- One sub-module, arb_watchdog: TIMEOUT counter plus sticky flag, inputs CLK, RST, active, outputs timeout.
- Starvation counter stays inline.

Test Plan:
- RST held mid-DGRANT with ramstate=BUSY -> next edge: ramREN=0, dwait=1, iwait=1, timeout=0, state IDLE.
- iREN=1, iaddr=0x0000_0040; RAM BUSY 3 cycles then ACCESS with ramload=0x8C01_0004 -> ramREN high from cycle 1, iwait=0 and iload=0x8C01_0004 only in cycle 4.
- iREN and dWEN both asserted in IDLE, daddr=0x100, dstore=0xDEAD_BEEF -> data granted first with ramWEN=1, ramaddr=0x100, ramstore=0xDEAD_BEEF; after dwait low, instruction granted.
- iREN held high with dREN re-requested every cycle, STARVE_MAX=4 -> exactly 4 data completions, then an instruction grant, then starve_cnt=0.
- ramstate=ERROR during IGRANT -> iwait stays 1, IDLE next cycle, re-grant; ACCESS on retry completes normally.
- dREN held with ramstate=BUSY for 64 cycles (TIMEOUT=64) -> timeout=1 at cycle 64 and remains 1 after a later ACCESS, until RST.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM handshake state, data word, arbiter FSM
// state and the RAM request payload driven by the arbiter.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic  ren;
    logic  wen;
    word_t addr;
    word_t store;
  } ram_req_t;

endpackage

// File: rtl/arb_watchdog.sv
// Access watchdog for the memory arbiter.
// Counts consecutive cycles spent in a grant state and raises a sticky flag
// once TIMEOUT such cycles have elapsed.
//   CLK     in   clock, rising edge
//   RST     in   synchronous active-high reset
//   active  in   high when the arbiter occupies a grant state next cycle
//   timeout out  sticky flag, cleared only by RST
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic active,
  output logic timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // cnt equals the number of grant cycles including the current one, so the
  // flag is visible in the cycle where the count reaches TIMEOUT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else if (!active) begin
      cnt <= '0;
    end else begin
      if (cnt != CNT_W'(TIMEOUT)) cnt <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(TIMEOUT - 1)) timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Instruction/data memory arbiter between the cache pair and the single RAM
// port. Registered-grant FSM with data priority, instruction anti-starvation
// and an access watchdog.
//   CLK, RST                  clock, synchronous active-high reset
//   iREN, iaddr               icache read request and address
//   iwait, iload              icache wait (low on completion) and read data
//   dREN, dWEN, daddr, dstore dcache request, address and write data
//   dwait, dload              dcache wait (low on completion) and read data
//   ramREN, ramWEN, ramaddr,
//   ramstore, ramload,
//   ramstate                  RAM port
//   timeout                   sticky watchdog flag
//   starve_cnt                consecutive data grants with iREN pending
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic              timeout,
  output logic [2:0]        starve_cnt
);

  localparam int unsigned STARVE_W = 3;

  arb_state_t          state;
  arb_state_t          state_next;
  logic [STARVE_W-1:0] starve_q;
  ram_req_t            req;
  logic                d_req;
  logic                starve_hit;
  logic                d_complete;
  logic                i_complete;

  assign d_req      = dREN | dWEN;
  assign starve_hit = iREN && (starve_q == STARVE_W'(STARVE_MAX));

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: abort, completion and error all fall back to IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (d_req && !starve_hit) state_next = DGRANT;
        else if (iREN)            state_next = IGRANT;
      end
      DGRANT: begin
        if (!d_req || ramstate == ACCESS || ramstate == ERROR) state_next = IDLE;
      end
      IGRANT: begin
        if (!iREN || ramstate == ACCESS || ramstate == ERROR) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: RAM drive and per-requester wait/load from the granted side only
  always_comb begin
    req        = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    d_complete = 1'b0;
    i_complete = 1'b0;
    case (state)
      DGRANT: begin
        if (d_req) begin
          req.addr  = daddr;
          req.wen   = dWEN;
          req.ren   = dREN & ~dWEN;
          req.store = dstore;
          if (ramstate == ACCESS) begin
            dwait      = 1'b0;
            dload      = ramload;
            d_complete = 1'b1;
          end
        end
      end
      IGRANT: begin
        if (iREN) begin
          req.addr = iaddr;
          req.ren  = 1'b1;
          if (ramstate == ACCESS) begin
            iwait      = 1'b0;
            iload      = ramload;
            i_complete = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign ramREN   = req.ren;
  assign ramWEN   = req.wen;
  assign ramaddr  = req.addr;
  assign ramstore = req.store;

  // Starvation counter: data completions with iREN pending, saturating
  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_q <= '0;
    end else if (i_complete) begin
      starve_q <= '0;
    end else if (d_complete) begin
      if (!iREN)                                 starve_q <= '0;
      else if (starve_q != STARVE_W'(STARVE_MAX)) starve_q <= starve_q + STARVE_W'(1);
    end
  end

  assign starve_cnt = starve_q;

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .CLK     (CLK),
    .RST     (RST),
    .active  (state_next != IDLE),
    .timeout (timeout)
  );

endmodule
